// File: rtl/gray_updown_counter.sv
// Up/down counter with a registered Gray-code copy of the count, load, wrap/saturate
// limits and terminal-count / wrap-pulse status.
module gray_updown_counter #(
    parameter int unsigned WIDTH = 4,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap_pulse
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2) begin : g_bad_width
        $error("gray_updown_counter: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (bin_q == MAX) begin
                    if (WRAP) begin
                        bin_d  = ZERO;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == ZERO) begin
                    if (WRAP) begin
                        bin_d  = MAX;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
        // Gray is encoded from the next binary value so both registers stay coherent.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= ZERO;
            gray_q <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out    = bin_q;
    assign gray_out   = gray_q;
    assign wrap_pulse = wrap_q;
    assign tc         = up_dn ? (bin_q == MAX) : (bin_q == ZERO);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: a 4-bit wrapping instance driven from a vector
// table, a 4-bit saturating instance and an 8-bit instance for the mid-count reset.
module tb_gray_updown_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // a_: WIDTH=4 WRAP=1, s_: WIDTH=4 WRAP=0, b_: WIDTH=8 WRAP=1
    logic       a_en, a_up, a_ld, a_tc, a_wr;
    logic [3:0] a_lb, a_bin, a_gray;
    logic       s_en, s_up, s_ld, s_tc, s_wr;
    logic [3:0] s_lb, s_bin, s_gray;
    logic       b_en, b_up, b_ld, b_tc, b_wr;
    logic [7:0] b_lb, b_bin, b_gray;

    gray_updown_counter #(.WIDTH(4), .WRAP(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up_dn(a_up), .load(a_ld), .load_bin(a_lb),
        .bin_out(a_bin), .gray_out(a_gray), .tc(a_tc), .wrap_pulse(a_wr));

    gray_updown_counter #(.WIDTH(4), .WRAP(1'b0)) u_s (
        .clk(clk), .rst_n(rst_n), .en(s_en), .up_dn(s_up), .load(s_ld), .load_bin(s_lb),
        .bin_out(s_bin), .gray_out(s_gray), .tc(s_tc), .wrap_pulse(s_wr));

    gray_updown_counter #(.WIDTH(8), .WRAP(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .up_dn(b_up), .load(b_ld), .load_bin(b_lb),
        .bin_out(b_bin), .gray_out(b_gray), .tc(b_tc), .wrap_pulse(b_wr));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en, up, ld;
        logic [3:0] lb, bin, gray;
        logic       tc, wr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic en, logic up, logic ld, logic [3:0] lb,
                                logic [3:0] bin, logic [3:0] gray, logic tc, logic wr);
        vec_t v;
        v.en = en; v.up = up; v.ld = ld; v.lb = lb;
        v.bin = bin; v.gray = gray; v.tc = tc; v.wr = wr;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] prev_gray;

        // Full up-count from 0 with wrap
        add(1,1,0,4'h0, 4'h1,4'h1,0,0);
        add(1,1,0,4'h0, 4'h2,4'h3,0,0);
        add(1,1,0,4'h0, 4'h3,4'h2,0,0);
        add(1,1,0,4'h0, 4'h4,4'h6,0,0);
        add(1,1,0,4'h0, 4'h5,4'h7,0,0);
        add(1,1,0,4'h0, 4'h6,4'h5,0,0);
        add(1,1,0,4'h0, 4'h7,4'h4,0,0);
        add(1,1,0,4'h0, 4'h8,4'hC,0,0);
        add(1,1,0,4'h0, 4'h9,4'hD,0,0);
        add(1,1,0,4'h0, 4'hA,4'hF,0,0);
        add(1,1,0,4'h0, 4'hB,4'hE,0,0);
        add(1,1,0,4'h0, 4'hC,4'hA,0,0);
        add(1,1,0,4'h0, 4'hD,4'hB,0,0);
        add(1,1,0,4'h0, 4'hE,4'h9,0,0);
        add(1,1,0,4'h0, 4'hF,4'h8,1,0);
        add(1,1,0,4'h0, 4'h0,4'h0,0,1);
        // Load beats enable, hold, down wrap, direction flips with back-to-back wraps
        add(1,1,1,4'hD, 4'hD,4'hB,0,0);
        add(0,1,0,4'h0, 4'hD,4'hB,0,0);
        add(0,0,1,4'h0, 4'h0,4'h0,1,0);
        add(1,0,0,4'h0, 4'hF,4'h8,0,1);
        add(1,0,0,4'h0, 4'hE,4'h9,0,0);
        add(1,1,0,4'h0, 4'hF,4'h8,1,0);
        add(1,1,0,4'h0, 4'h0,4'h0,0,1);
        add(1,0,0,4'h0, 4'hF,4'h8,0,1);

        a_en = 1; a_up = 1; a_ld = 1; a_lb = 4'h5;
        s_en = 1; s_up = 1; s_ld = 1; s_lb = 4'h5;
        b_en = 1; b_up = 1; b_ld = 1; b_lb = 8'h55;

        // Reset overrides load and enable
        rst_n = 0;
        step();
        step();
        chk("rst_a_bin", a_bin, 0);  chk("rst_a_gray", a_gray, 0); chk("rst_a_wrap", a_wr, 0);
        chk("rst_s_bin", s_bin, 0);  chk("rst_b_bin", b_bin, 0);   chk("rst_b_gray", b_gray, 0);

        rst_n = 1;
        a_en = 0; a_ld = 0; s_en = 0; s_ld = 0; b_en = 0; b_ld = 0;
        step();
        chk("hold_a_bin", a_bin, 0); chk("hold_a_gray", a_gray, 0); chk("hold_a_wrap", a_wr, 0);
        chk("hold_b_bin", b_bin, 0);

        prev_gray = 4'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            a_en = vecs[i].en; a_up = vecs[i].up; a_ld = vecs[i].ld; a_lb = vecs[i].lb;
            step();
            chk($sformatf("v%0d_bin", i),  a_bin,  vecs[i].bin);
            chk($sformatf("v%0d_gray", i), a_gray, vecs[i].gray);
            chk($sformatf("v%0d_tc", i),   a_tc,   vecs[i].tc);
            chk($sformatf("v%0d_wrap", i), a_wr,   vecs[i].wr);
            if (vecs[i].en && !vecs[i].ld)
                chk($sformatf("v%0d_onebit", i), $countones(prev_gray ^ a_gray), 1);
            prev_gray = a_gray;
        end
        a_en = 0; a_ld = 0;

        // Saturation at MAX with WRAP=0
        s_ld = 1; s_lb = 4'hE; s_up = 1;
        step();
        chk("sat_load", s_bin, 4'hE);
        s_ld = 0; s_en = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sat%0d_bin", k),  s_bin,  4'hF);
            chk($sformatf("sat%0d_gray", k), s_gray, 4'h8);
            chk($sformatf("sat%0d_wrap", k), s_wr,   0);
            chk($sformatf("sat%0d_tc", k),   s_tc,   1);
        end
        s_up = 0; s_en = 0;
        #1;
        chk("sat_dir_tc", s_tc, 0);
        s_en = 1;
        step();
        chk("sat_down_bin", s_bin, 4'hE);
        chk("sat_down_gray", s_gray, 4'h9);
        // Saturation at 0
        s_en = 0; s_ld = 1; s_lb = 4'h0;
        step();
        s_ld = 0; s_en = 1;
        step();
        chk("sat0_bin", s_bin, 4'h0);
        chk("sat0_wrap", s_wr, 0);
        chk("sat0_tc", s_tc, 1);
        s_en = 0;

        // 8-bit: count up from 0x7E, reset at the would-be wrap
        b_ld = 1; b_lb = 8'h7E; b_up = 1;
        step();
        b_ld = 0; b_en = 1;
        for (int k = 0; k < 129; k++) step();
        chk("b_pre_bin", b_bin, 8'hFF);
        chk("b_pre_gray", b_gray, 8'h80);
        chk("b_pre_tc", b_tc, 1);
        rst_n = 0;
        step();
        chk("b_rst_bin", b_bin, 0);
        chk("b_rst_gray", b_gray, 0);
        chk("b_rst_wrap", b_wr, 0);
        rst_n = 1; b_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
